// File: rtl/axi_lite_slave_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes,
// write/read FSM encodings and the byte-lane merge helper.
package axi_lite_slave_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_WAIT_ADDR = 2'd1,
    W_WAIT_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// NUM_REGS x 32 register array with a byte-enable write port and a
// registered read port; a read on the same edge as a write sees the old value.
module axi_lite_regbank
  import axi_lite_slave_regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic             rd_en,
  input  logic             rd_hit,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= byte_merge(regs[wr_idx], wr_data, wr_strb);
    end
  end

  // Misses read as zero; the value is held until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_hit ? regs[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave register file: one outstanding write and one outstanding
// read, handled by independent FSMs on top of axi_lite_regbank.
module axi_lite_slave_regfile
  import axi_lite_slave_regfile_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'hC7000000,
  parameter int C_NUM_REGS = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDX_W   = $clog2(C_NUM_REGS);
  localparam int TAG_LSB = IDX_W + 2;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                          ready_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic [1:0]                    bresp_q;
  logic [1:0]                    rresp_q;

  logic                          aw_hs, w_hs, ar_hs, commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;
  logic                          wr_hit, rd_hit;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Take address/data from the bus when the handshake is happening now,
  // otherwise from what an earlier handshake latched.
  assign wr_addr = aw_hs ? S_AXI_AWADDR : aw_addr_q;
  assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;

  assign wr_hit = (wr_addr[C_S_AXI_ADDR_WIDTH-1:TAG_LSB] ==
                   C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB]);
  assign rd_hit = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB] ==
                   C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB]);

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

  // Keeps every ready low until the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_hs)  aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs)  rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en;
        S_AXI_WREADY  = ready_en;
        if (ready_en) begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            w_next = W_RESP;
            commit = 1'b1;
          end else if (S_AXI_AWVALID) begin
            w_next = W_WAIT_DATA;
          end else if (S_AXI_WVALID) begin
            w_next = W_WAIT_ADDR;
          end
        end
      end
      W_WAIT_ADDR: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) begin
          w_next = W_RESP;
          commit = 1'b1;
        end
      end
      W_WAIT_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) begin
          w_next = W_RESP;
          commit = 1'b1;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (ready_en && S_AXI_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RRESP = rresp_q;

  axi_lite_regbank #(
    .NUM_REGS (C_NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .wr_en   (commit && wr_hit),
    .wr_idx  (wr_addr[TAG_LSB-1:2]),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (ar_hs),
    .rd_hit  (rd_hit),
    .rd_idx  (S_AXI_ARADDR[TAG_LSB-1:2]),
    .rd_data (S_AXI_RDATA)
  );

endmodule

// File: doc/axi_lite_slave_regfile.md
AXI_LITE_SLAVE_REGFILE -- requirements
Module: axi_lite_slave_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter C_BASE_ADDR, default 32'hC7000000, base of the register window.
REQ-004 SHALL have parameter C_NUM_REGS, default 16, number of 32-bit registers; power of two, 2..256.
REQ-005 SHALL have port S_AXI_ACLK, in, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port S_AXI_ARESETN, in, 1, reset: asynchronous, active-low.
REQ-007 SHALL have ports S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-008 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-009 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-010 SHALL have ports S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-011 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.

Function
REQ-012 SHALL be the AXI4-Lite slave consuming the AXI traffic produced upstream; single outstanding write and single outstanding read, paths independent.
REQ-013 SHALL decode hit = address[ADDR_WIDTH-1:log2(NUM_REGS)+2] equals the same bits of C_BASE_ADDR; index = address[log2(NUM_REGS)+1:2]; address[1:0] ignored.
REQ-014 Write FSM SHALL have states W_IDLE, W_WAIT_ADDR, W_WAIT_DATA, W_RESP.
REQ-015 In W_IDLE, AWREADY=1 and WREADY=1; AW-only handshake -> W_WAIT_DATA (address latched, AWREADY=0); W-only -> W_WAIT_ADDR (data/strobe latched, WREADY=0); both same cycle -> W_RESP.
REQ-016 W_WAIT_ADDR/W_WAIT_DATA SHALL keep only the missing channel ready; completing handshake -> W_RESP.
REQ-017 On entry to W_RESP (edge after final handshake), hit SHALL update bytes with WSTRB=1 only, BRESP=2'b00; miss SHALL leave registers unchanged, BRESP=2'b10; BVALID=1 from that edge.
REQ-018 In W_RESP, AWREADY=WREADY=0; BVALID/BRESP SHALL hold stable until BVALID&&BREADY, then -> W_IDLE.
REQ-019 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-020 AR handshake at cycle N SHALL give RVALID=1 at N+1 with RDATA = register contents sampled at N; miss -> RDATA=0, RRESP=2'b10; hit -> RRESP=2'b00.
REQ-021 RDATA/RRESP/RVALID SHALL hold stable until RVALID&&RREADY, then -> R_IDLE; next AR accepted no earlier than the following cycle.
REQ-022 Write commit and read sample of the same register on the same edge: read SHALL return the pre-write value.
REQ-023 WSTRB=4'b0000 on a hit SHALL change nothing and return OKAY.
REQ-024 BREADY or RREADY held low indefinitely SHALL stall only that path; the other path keeps operating.

Reset
REQ-025 Asserting S_AXI_ARESETN low SHALL immediately force: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, all registers 0, FSMs to W_IDLE/R_IDLE.
REQ-026 Reset mid-transaction SHALL abandon it with no register update and no response.
REQ-027 Ready outputs SHALL assert no earlier than the first rising edge after reset deasserts.

Structure
REQ-028 Shared package/include SHALL hold response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 plus both FSM state encodings.
REQ-029 SHALL instantiate one sub-module, axi_lite_regbank: NUM_REGS x 32 array with a byte-enable write port and a registered read port.
REQ-030 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-031 AW+W same cycle, addr C7000008, data 12345678, strb F -> BVALID next cycle, BRESP 00; read C7000008 -> RDATA 12345678, RRESP 00.
REQ-032 W two cycles before AW, addr C700003C, data A5A5A5A5, strb 5 (prior contents FFFFFFFF) -> reg 15 = FFA5FFA5, BRESP 00.
REQ-033 Write to C7000040 (miss) -> BRESP 10, registers unchanged; read C7000040 -> RDATA 0, RRESP 10.
REQ-034 BREADY low 10 cycles, then a read issued -> BVALID/BRESP stable throughout, read completes; single AW/W accepted.
REQ-035 16 writes of index*0x11111111 to C7000000..C700003C, then 16 reads -> all values match with OKAY.
REQ-036 Reset asserted during W_WAIT_DATA after AW to C7000004 -> no BVALID, reg 1 = 0, all outputs at reset values immediately.
